// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the mantissa divider controller: state encoding,
// steps retired per clock and the resulting RUN cycle count.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int STEPS_PER_CYCLE = 4;

   function automatic int div_cycles(input int width);
      return width / STEPS_PER_CYCLE;
   endfunction

endpackage

// File: rtl/div_step4.sv
// Combinational block applying STEPS_PER_CYCLE restoring radix-2 division
// steps to the running dividend shift register, partial remainder and quotient.
module div_step4
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] n_nxt,
   output logic [WIDTH:0]   r_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH-1:0] n_t;
   logic [WIDTH:0]   r_t;
   logic [WIDTH-1:0] q_t;
   logic [WIDTH:0]   d_ext;

   assign d_ext = {1'b0, d};

   always_comb begin
      n_t = n;
      r_t = r;
      q_t = q;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
         r_t = {r_t[WIDTH-1:0], n_t[WIDTH-1]};
         n_t = n_t << 1;
         if (r_t >= d_ext) begin
            r_t = r_t - d_ext;
            q_t = {q_t[WIDTH-2:0], 1'b1};
         end else begin
            q_t = {q_t[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign n_nxt = n_t;
   assign r_nxt = r_t;
   assign q_nxt = q_t;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned mantissa divider controller: valid/ready operand intake,
// WIDTH/4 cycles of 4-step restoring division, valid/ready result delivery.
module div_sequencer
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'((div_cycles(WIDTH) - 1) * STEPS_PER_CYCLE);
   localparam logic [CW-1:0] STEP_INC   = CW'(STEPS_PER_CYCLE);

   div_state_t       state;
   logic [WIDTH-1:0] n_q;
   logic [WIDTH-1:0] d_q;
   logic [WIDTH:0]   r_q;
   logic [WIDTH-1:0] q_q;
   logic [CW-1:0]    count;
   logic             zero_q;

   logic [WIDTH-1:0] n_nxt;
   logic [WIDTH:0]   r_nxt;
   logic [WIDTH-1:0] q_nxt;

   div_step4 #(.WIDTH(WIDTH)) u_step (
      .n     (n_q),
      .d     (d_q),
      .r     (r_q),
      .q     (q_q),
      .n_nxt (n_nxt),
      .r_nxt (r_nxt),
      .q_nxt (q_nxt)
   );

   assign start_ready  = (state == IDLE);
   assign result_valid = (state == DONE);
   assign busy         = (state == RUN) || (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         n_q         <= '0;
         d_q         <= '0;
         r_q         <= '0;
         q_q         <= '0;
         count       <= '0;
         zero_q      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (flush) begin
         state  <= IDLE;
         count  <= '0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  n_q    <= dividend;
                  d_q    <= divisor;
                  r_q    <= '0;
                  q_q    <= '0;
                  count  <= '0;
                  zero_q <= (divisor == '0);
                  state  <= RUN;
               end
            end
            RUN: begin
               // A zero divisor spends one cycle here so its result lands one cycle after accept.
               if (zero_q) begin
                  quotient    <= '1;
                  remainder   <= n_q;
                  div_by_zero <= 1'b1;
                  zero_q      <= 1'b0;
                  state       <= DONE;
               end else begin
                  n_q   <= n_nxt;
                  r_q   <= r_nxt;
                  q_q   <= q_nxt;
                  count <= count + STEP_INC;
                  if (count == LAST_COUNT) begin
                     quotient    <= q_nxt;
                     remainder   <= r_nxt[WIDTH-1:0];
                     div_by_zero <= 1'b0;
                     state       <= DONE;
                  end
               end
            end
            DONE: begin
               if (result_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer at WIDTH=12 with hand-computed results.
module tb_div_sequencer;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        start_valid;
   logic        start_ready;
   logic [11:0] dividend;
   logic [11:0] divisor;
   logic        result_valid;
   logic        result_ready;
   logic [11:0] quotient;
   logic [11:0] remainder;
   logic        div_by_zero;
   logic        busy;

   int errors = 0;
   int checks = 0;

   div_sequencer #(.WIDTH(12)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .dividend     (dividend),
      .divisor      (divisor),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .quotient     (quotient),
      .remainder    (remainder),
      .div_by_zero  (div_by_zero),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [11:0] a, input logic [11:0] b);
      start_valid = 1'b1;
      dividend    = a;
      divisor     = b;
      step();
      start_valid = 1'b0;
      chk("accept_start_ready", start_ready, 0);
      chk("accept_busy", busy, 1);
   endtask

   task automatic wait_result(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!result_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
   endtask

   task automatic release_result();
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("release_start_ready", start_ready, 1);
      chk("release_result_valid", result_valid, 0);
   endtask

   task automatic do_div(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] eq, input logic [11:0] er, input logic ez,
                         input int lat);
      accept(a, b);
      wait_result(tag, lat);
      chk({tag, "_quotient"}, quotient, eq);
      chk({tag, "_remainder"}, remainder, er);
      chk({tag, "_dbz"}, div_by_zero, ez);
      release_result();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
      dividend = '0; divisor = '0;
      step();
      step();
      chk("rst_start_ready", start_ready, 1);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", div_by_zero, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();

      do_div("d100_7", 12'd100, 12'd7, 12'd14, 12'd2, 1'b0, 3);
      do_div("d4095_1", 12'd4095, 12'd1, 12'd4095, 12'd0, 1'b0, 3);
      do_div("d3_10", 12'd3, 12'd10, 12'd0, 12'd3, 1'b0, 3);
      do_div("d4095_4095", 12'd4095, 12'd4095, 12'd1, 12'd0, 1'b0, 3);
      do_div("d5_0", 12'd5, 12'd0, 12'hFFF, 12'd5, 1'b1, 1);
      do_div("d2730_5", 12'd2730, 12'd5, 12'd546, 12'd0, 1'b0, 3);

      // Backpressure with a competing operand offer
      accept(12'd100, 12'd7);
      wait_result("bp", 3);
      start_valid = 1'b1; dividend = 12'd9; divisor = 12'd3;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", result_valid, 1);
         chk("bp_start_ready", start_ready, 0);
         chk("bp_quotient", quotient, 14);
         chk("bp_remainder", remainder, 2);
      end
      start_valid = 1'b0;
      release_result();
      do_div("d9_3", 12'd9, 12'd3, 12'd3, 12'd0, 1'b0, 3);

      // Asynchronous reset in the middle of RUN
      accept(12'd100, 12'd7);
      step();
      rst_n = 1'b0;
      #1;
      chk("amid_start_ready", start_ready, 1);
      chk("amid_result_valid", result_valid, 0);
      chk("amid_busy", busy, 0);
      chk("amid_quotient", quotient, 0);
      chk("amid_remainder", remainder, 0);
      chk("amid_dbz", div_by_zero, 0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("amid_no_result", result_valid, 0);
      end

      // Flush while running
      accept(12'd100, 12'd7);
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("frun_start_ready", start_ready, 1);
      chk("frun_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("frun_no_result", result_valid, 0);
      end

      // Flush while holding a result
      accept(12'd100, 12'd7);
      wait_result("fdone", 3);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fdone_valid", result_valid, 0);
      chk("fdone_start_ready", start_ready, 1);
      step();
      chk("fdone_still_idle", result_valid, 0);

      do_div("d200_13", 12'd200, 12'd13, 12'd15, 12'd5, 1'b0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
